id_scoreboard: RTL and testbench

// - Register-hazard scoreboard beside the decode stage; generalises decode-time forwarding to variable-latency units (mul/div, loads).
// - Holds a per-register countdown of cycles until a pending result appears on the forwarding path.
// - Gates issue while a read operand or an out-of-order write-back (WAW) hazard is unresolved.

---
 rtl/id_scoreboard.sv | 107 ++++++++++
 tb/tb_id_scoreboard.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/id_scoreboard.sv
// id_scoreboard: register-hazard scoreboard beside the decode stage.
// Each tracked register holds a countdown of cycles until its pending result
// reaches the forwarding path. Issue is gated on RAW (operand still pending)
// and WAW (an older, slower write would land after this one).
// Optional feature macro: SCOREBOARD_PERF_EN adds 32-bit stall counters
// stall_raw_cnt / stall_waw_cnt.
// Handshake: issue_ready is a pure function of the operands and the counters
// (never of issue_valid); an instruction fires in any cycle where
// issue_valid & issue_ready & ~flush, and is recorded at that clock edge.
module id_scoreboard #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int MAX_LAT  = 7,
  parameter int LAT_W    = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                issue_valid,
  output logic                issue_ready,
  input  logic                rs1_read,
  input  logic [ADDR_W-1:0]   rs1_addr,
  input  logic                rs2_read,
  input  logic [ADDR_W-1:0]   rs2_addr,
  input  logic                wreg,
  input  logic [ADDR_W-1:0]   wd,
  input  logic [LAT_W-1:0]    lat,
  input  logic                flush,
  output logic [NUM_REGS-1:0] busy_vec,
`ifdef SCOREBOARD_PERF_EN
  output logic [31:0]         stall_raw_cnt,
  output logic [31:0]         stall_waw_cnt,
`endif
  output logic                stall_o
);

  logic [LAT_W-1:0] r_cnt [NUM_REGS];

  logic [LAT_W-1:0] w_lat_eff;
  logic             w_raw;
  logic             w_waw;
  logic             w_fire;
  logic             w_write;

  // Illegal latencies (0 or above MAX_LAT) are treated as the slowest unit.
  always_comb begin
    w_lat_eff = lat;
    if (lat == '0 || int'(lat) > MAX_LAT) begin
      w_lat_eff = LAT_W'(MAX_LAT);
    end
  end

  // Hazards look at pre-edge counters; register 0 is never pending.
  always_comb begin
    w_raw = (rs1_read && rs1_addr != '0 && r_cnt[rs1_addr] != '0) ||
            (rs2_read && rs2_addr != '0 && r_cnt[rs2_addr] != '0);
    w_waw = wreg && wd != '0 && r_cnt[wd] > w_lat_eff;
    issue_ready = !(w_raw || w_waw);
    // Reset suppresses both stalls and recording of the presented instruction.
    stall_o = issue_valid && !issue_ready && !flush && !rst;
    w_fire  = issue_valid && issue_ready && !flush && !rst;
    w_write = w_fire && wreg && wd != '0;
  end

  // Per-register countdown: a new write reloads, otherwise decrement to zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        r_cnt[r] <= '0;
      end
    end else begin
      r_cnt[0] <= '0;
      for (int r = 1; r < NUM_REGS; r++) begin
        if (w_write && wd == ADDR_W'(r)) begin
          r_cnt[r] <= w_lat_eff;
        end else if (r_cnt[r] != '0) begin
          r_cnt[r] <= r_cnt[r] - 1'b1;
        end
      end
    end
  end

  // Busy flags come straight from the counter registers.
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      busy_vec[r] = (r_cnt[r] != '0);
    end
  end

`ifdef SCOREBOARD_PERF_EN
  // Stall cycle counters by cause; both step when both hazards are present.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_raw_cnt <= '0;
      stall_waw_cnt <= '0;
    end else begin
      if (stall_o && w_raw) stall_raw_cnt <= stall_raw_cnt + 32'd1;
      if (stall_o && w_waw) stall_waw_cnt <= stall_waw_cnt + 32'd1;
    end
  end
`endif

`ifndef SYNTHESIS
  a_lat_legal: assert property (@(posedge clk) disable iff (rst)
    (issue_valid && wreg && wd != '0 && !flush) |-> (lat != '0 && int'(lat) <= MAX_LAT));
`endif

endmodule

// File: tb/tb_id_scoreboard.sv
// tb_id_scoreboard: directed and random stimulus for id_scoreboard.
// Reference model keeps, per register, the absolute cycle at which its
// pending result becomes available; counters are never modelled directly.
module tb_id_scoreboard;

  localparam int W = 34;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        issue_valid = 1'b0;
  logic        issue_ready;
  logic        rs1_read = 1'b0;
  logic [4:0]  rs1_addr = '0;
  logic        rs2_read = 1'b0;
  logic [4:0]  rs2_addr = '0;
  logic        wreg = 1'b0;
  logic [4:0]  wd = '0;
  logic [2:0]  lat = 3'd1;
  logic        flush = 1'b0;
  logic [31:0] busy_vec;
  logic        stall_o;
`ifdef SCOREBOARD_PERF_EN
  logic [31:0] stall_raw_cnt;
  logic [31:0] stall_waw_cnt;
`endif

  int total = 0;
  int bad   = 0;

  logic [W-1:0] exp_q[$];

  // Model: free_at[r] = cycle index from which register r is no longer pending.
  int          free_at [32];
  int          k = 0;
  int unsigned m_raw = 0;
  int unsigned m_waw = 0;

  id_scoreboard dut (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_ready(issue_ready),
    .rs1_read(rs1_read), .rs1_addr(rs1_addr), .rs2_read(rs2_read), .rs2_addr(rs2_addr),
    .wreg(wreg), .wd(wd), .lat(lat), .flush(flush), .busy_vec(busy_vec),
`ifdef SCOREBOARD_PERF_EN
    .stall_raw_cnt(stall_raw_cnt), .stall_waw_cnt(stall_waw_cnt),
`endif
    .stall_o(stall_o)
  );

  // Clock
  always #5 clk = ~clk;

  function automatic bit pending(input logic [4:0] r);
    return (r != 5'd0) && (free_at[r] > k);
  endfunction

  // Drive one cycle, push the expected response, then advance the model.
  task automatic drive(input bit r_i, input bit v, input bit r1, input logic [4:0] a1,
                       input bit r2, input logic [4:0] a2, input bit w,
                       input logic [4:0] d, input logic [2:0] l, input bit fl);
    bit raw, waw, rdy, stl;
    logic [31:0] bv;
    rst = r_i; issue_valid = v; rs1_read = r1; rs1_addr = a1; rs2_read = r2;
    rs2_addr = a2; wreg = w; wd = d; lat = l; flush = fl;
    raw = (r1 && pending(a1)) || (r2 && pending(a2));
    waw = w && d != 5'd0 && (free_at[d] - k) > int'(l);
    rdy = !(raw || waw);
    stl = v && !rdy && !fl && !r_i;
    for (int r = 0; r < 32; r++) bv[r] = pending(5'(r));
    exp_q.push_back({rdy, stl, bv});
    @(posedge clk);
    if (r_i) begin
      for (int r = 0; r < 32; r++) free_at[r] = 0;
      m_raw = 0; m_waw = 0;
    end else begin
      if (stl && raw) m_raw++;
      if (stl && waw) m_waw++;
      if (v && rdy && !fl && w && d != 5'd0) free_at[d] = k + 1 + int'(l);
    end
    k++;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, 3'd1, 0);
  endtask

  task automatic prod(input logic [4:0] d, input logic [2:0] l);
    drive(0, 1, 0, 0, 0, 0, 1, d, l, 0);
  endtask

  task automatic cons(input logic [4:0] a, input bit fl);
    drive(0, 1, 1, a, 0, 0, 0, 0, 3'd1, fl);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    total++;
    if (got !== req) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, got, req);
    end
  endtask

  // Monitor: compare DUT outputs against the scoreboard mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [W-1:0] e;
      logic [W-1:0] g;
      e = exp_q.pop_front();
      g = {issue_ready, stall_o, busy_vec};
      total++;
      if (g !== e) begin
        bad++;
        $display("FAIL cycle%0d got ready=%b stall=%b busy=%h want ready=%b stall=%b busy=%h",
                 k, g[33], g[32], g[31:0], e[33], e[32], e[31:0]);
      end
    end
  end

  initial begin
    for (int r = 0; r < 32; r++) free_at[r] = 0;
    // First reset cycle: counters not yet defined, so no check.
    issue_valid = 1'b1;
    @(posedge clk); k++; #1;
    // Second reset cycle with an instruction presented.
    drive(1, 1, 1, 5'd5, 1, 5'd6, 1, 5'd7, 3'd3, 0);
    idle(1);

    // RAW: producer r5 lat 3, one idle cycle, then dependant (2 stalls, fires 3rd).
    prod(5'd5, 3'd3);
    idle(1);
    for (int i = 0; i < 3; i++) cons(5'd5, 0);
    idle(1);

    // WAW: r8 pending at 4, younger write lat 1 waits until cnt<=1.
    prod(5'd8, 3'd4);
    for (int i = 0; i < 4; i++) prod(5'd8, 3'd1);
    idle(2);

    // Register 0 is never tracked.
    prod(5'd0, 3'd7);
    cons(5'd0, 0);

    // Flush: hazarded instruction never stalls; unhazarded one is not recorded.
    prod(5'd9, 3'd5);
    cons(5'd9, 1);
    drive(0, 1, 0, 0, 0, 0, 1, 5'd10, 3'd3, 1);
    idle(5);

    // Reset mid-countdown, then immediate issue of a reader of r3.
    prod(5'd3, 3'd6);
    drive(1, 1, 1, 5'd3, 0, 0, 0, 0, 3'd1, 0);
    cons(5'd3, 0);
    idle(1);

`ifdef SCOREBOARD_PERF_EN
    // Two RAW stall cycles followed by three WAW stall cycles.
    drive(1, 0, 0, 0, 0, 0, 0, 0, 3'd1, 0);
    prod(5'd4, 3'd2);
    for (int i = 0; i < 3; i++) cons(5'd4, 0);
    prod(5'd6, 3'd4);
    for (int i = 0; i < 4; i++) prod(5'd6, 3'd1);
    check("perf_raw", stall_raw_cnt, 32'd2);
    check("perf_waw", stall_waw_cnt, 32'd3);
`endif

    // Random traffic on a narrow register window to provoke hazards.
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 59) == 0, $urandom_range(0, 3) != 0,
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
            3'($urandom_range(1, 7)), $urandom_range(0, 7) == 0);
    end
    idle(8);

`ifdef SCOREBOARD_PERF_EN
    check("perf_raw_rand", stall_raw_cnt, m_raw);
    check("perf_waw_rand", stall_waw_cnt, m_waw);
`endif

    @(negedge clk); #1;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
